// File: rtl/process_element_div_23s_15ns_8s_pkg.sv
// Shared definitions for the signed/unsigned restoring divider.
//   - default operand widths
//   - FSM state encoding
//   - quotient saturation limits
package process_element_div_23s_15ns_8s_pkg;

    localparam int DIVIDEND_W_DEF = 23;
    localparam int DIVISOR_W_DEF  = 15;
    localparam int QUOT_W_DEF     = 8;

    localparam int QUOT_MAX = (2 ** (QUOT_W_DEF - 1)) - 1;
    localparam int QUOT_MIN = -(2 ** (QUOT_W_DEF - 1));

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/process_element_div_23s_15ns_8s_if.sv
// Handshake/data bundle for the divider.
//   master : producer/consumer side (drives operands and out_ready)
//   slave  : divider side (drives in_ready and results)
interface process_element_div_23s_15ns_8s_if #(
    parameter int DIVIDEND_W = 23,
    parameter int DIVISOR_W  = 15,
    parameter int QUOT_W     = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DIVIDEND_W-1:0] dividend;
    logic [DIVISOR_W-1:0]  divisor;
    logic                  out_valid;
    logic                  out_ready;
    logic [QUOT_W-1:0]     quot;
    logic [DIVISOR_W:0]    rem;
    logic                  sat;
    logic                  div_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quot, rem, sat, div_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quot, rem, sat, div_zero
    );
endinterface

// File: rtl/process_element_div_step.sv
// One restoring shift-subtract step.
//   rem_i     : partial remainder (always < divisor)
//   bit_i     : next dividend bit, MSB first
//   divisor_i : unsigned divisor
//   rem_o     : updated partial remainder
//   q_o       : quotient bit produced by this step
module process_element_div_step #(
    parameter int DIVISOR_W = 15
) (
    input  logic [DIVISOR_W-1:0] rem_i,
    input  logic                 bit_i,
    input  logic [DIVISOR_W-1:0] divisor_i,
    output logic [DIVISOR_W-1:0] rem_o,
    output logic                 q_o
);
    logic [DIVISOR_W:0] shifted;
    logic [DIVISOR_W:0] divisor_ext;

    always_comb begin
        shifted     = {rem_i, bit_i};
        divisor_ext = {1'b0, divisor_i};
        q_o         = 1'b0;
        rem_o       = shifted[DIVISOR_W-1:0];
        // The difference always fits DIVISOR_W bits when it is taken,
        // because the partial remainder is kept below the divisor.
        if (shifted >= divisor_ext) begin
            q_o   = 1'b1;
            rem_o = DIVISOR_W'(shifted - divisor_ext);
        end
    end
endmodule

// File: rtl/process_element_div_23s_15ns_8s.sv
// Signed dividend / unsigned divisor restoring divider with saturated
// signed quotient and signed remainder (sign follows the dividend).
//   clk, reset (sync, active high), ce (global clock enable)
//   bus        : slave side of the handshake/data interface
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | in_ready high (with ce); waiting for an operand pair
// CALC  | DIVIDEND_W shift-subtract steps, then one cycle to finalise
// DONE  | out_valid high; results held until out_ready
module process_element_div_23s_15ns_8s
    import process_element_div_23s_15ns_8s_pkg::*;
#(
    parameter int DIVIDEND_W = DIVIDEND_W_DEF,
    parameter int DIVISOR_W  = DIVISOR_W_DEF,
    parameter int QUOT_W     = QUOT_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic ce,
    process_element_div_23s_15ns_8s_if.slave bus
);
    localparam int CNT_W = $clog2(DIVIDEND_W + 1);
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(DIVIDEND_W);
    localparam logic [QUOT_W-1:0]     Q_MAX    = QUOT_W'(QUOT_MAX);
    localparam logic [QUOT_W-1:0]     Q_MIN    = QUOT_W'(QUOT_MIN);
    localparam logic [DIVIDEND_W-1:0] POS_LIM  = DIVIDEND_W'(QUOT_MAX);
    localparam logic [DIVIDEND_W-1:0] NEG_LIM  = DIVIDEND_W'(-QUOT_MIN);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    // Holds the dividend magnitude; quotient bits shift in from the LSB
    // as magnitude bits shift out of the MSB.
    logic [DIVIDEND_W-1:0] acc_q, acc_d;
    logic [DIVISOR_W-1:0]  prem_q, prem_d;
    logic [DIVISOR_W-1:0]  div_q, div_d;
    logic                  neg_q, neg_d;
    logic [QUOT_W-1:0]     quot_q, quot_d;
    logic [DIVISOR_W:0]    rem_q, rem_d;
    logic                  sat_q, sat_d;
    logic                  dz_q, dz_d;

    logic [DIVISOR_W-1:0]  step_rem;
    logic                  step_q;
    logic [DIVISOR_W:0]    rem_mag;

    process_element_div_step #(
        .DIVISOR_W (DIVISOR_W)
    ) u_step (
        .rem_i     (prem_q),
        .bit_i     (acc_q[DIVIDEND_W-1]),
        .divisor_i (div_q),
        .rem_o     (step_rem),
        .q_o       (step_q)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        prem_d  = prem_q;
        div_d   = div_q;
        neg_d   = neg_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        sat_d   = sat_q;
        dz_d    = dz_q;
        rem_mag = {1'b0, prem_q};

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    neg_d   = bus.dividend[DIVIDEND_W-1];
                    // Two's-complement negate in DIVIDEND_W unsigned bits;
                    // the most negative dividend maps to 2^(DIVIDEND_W-1).
                    acc_d   = neg_d ? (~bus.dividend + 1'b1) : bus.dividend;
                    div_d   = bus.divisor;
                    prem_d  = '0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (cnt_q == CNT_LAST) begin
                    // With a zero divisor every step subtracts nothing, so
                    // prem holds the low DIVISOR_W bits of the magnitude.
                    rem_d = neg_q ? (-rem_mag) : rem_mag;
                    if (div_q == '0) begin
                        dz_d   = 1'b1;
                        sat_d  = 1'b1;
                        quot_d = neg_q ? Q_MIN : Q_MAX;
                    end else begin
                        dz_d = 1'b0;
                        if (!neg_q) begin
                            sat_d  = (acc_q > POS_LIM);
                            quot_d = sat_d ? Q_MAX : acc_q[QUOT_W-1:0];
                        end else begin
                            sat_d  = (acc_q > NEG_LIM);
                            quot_d = sat_d ? Q_MIN : (-acc_q[QUOT_W-1:0]);
                        end
                    end
                    state_d = DONE;
                end else begin
                    acc_d  = {acc_q[DIVIDEND_W-2:0], step_q};
                    prem_d = step_rem;
                    cnt_d  = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            prem_q  <= '0;
            div_q   <= '0;
            neg_q   <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            sat_q   <= 1'b0;
            dz_q    <= 1'b0;
        end else if (ce) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            prem_q  <= prem_d;
            div_q   <= div_d;
            neg_q   <= neg_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            sat_q   <= sat_d;
            dz_q    <= dz_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE) && ce;
    assign bus.out_valid = (state_q == DONE);
    assign bus.quot      = quot_q;
    assign bus.rem       = rem_q;
    assign bus.sat       = sat_q;
    assign bus.div_zero  = dz_q;

endmodule

// File: tb/tb_process_element_div_23s_15ns_8s.sv
module tb_process_element_div_23s_15ns_8s;

    typedef struct {
        logic [7:0]  q;
        logic [15:0] r;
        logic        sat;
        logic        dz;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic ce;
    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    process_element_div_23s_15ns_8s_if #(
        .DIVIDEND_W (23),
        .DIVISOR_W  (15),
        .QUOT_W     (8)
    ) bus ();

    process_element_div_23s_15ns_8s #(
        .DIVIDEND_W (23),
        .DIVISOR_W  (15),
        .QUOT_W     (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .ce    (ce),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t model(input longint a, input longint b);
        exp_t   e;
        longint q;
        longint r;
        longint m;
        e.sat = 1'b0;
        e.dz  = 1'b0;
        if (b == 0) begin
            e.dz  = 1'b1;
            e.sat = 1'b1;
            q = (a >= 0) ? 127 : -128;
            m = (a < 0) ? -a : a;
            r = m % 32768;
            if (a < 0) r = -r;
        end else begin
            q = a / b;
            r = a % b;
            if (q > 127) begin
                q = 127;
                e.sat = 1'b1;
            end else if (q < -128) begin
                q = -128;
                e.sat = 1'b1;
            end
        end
        e.q = 8'(q);
        e.r = 16'(r);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic run_op(input int a, input int b, input bit tog, input bit junk, input int hold);
        exp_t e;
        int   k;
        int   edges;
        @(negedge clk);
        ce           = 1'b1;
        bus.dividend = 23'(a);
        bus.divisor  = 15'(b);
        bus.in_valid = 1'b1;
        #1;
        k = 0;
        while (!bus.in_ready && k < 50) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("accept", 32'(k < 50), 32'd1);
        sb.push_back(model(a, b));
        @(posedge clk);
        #1;
        if (junk) begin
            bus.dividend = 23'h7FFFFF;
            bus.divisor  = 15'd1;
        end else begin
            bus.in_valid = 1'b0;
        end
        edges = 0;
        while (!bus.out_valid && edges < 200) begin
            if (tog) ce = edges[0];
            if (!tog && edges == 5) chk("in_ready_busy", 32'(bus.in_ready), 32'd0);
            @(posedge clk);
            #1;
            edges++;
        end
        ce           = 1'b1;
        bus.in_valid = 1'b0;
        chk("latency", 32'(edges), tog ? 32'd48 : 32'd24);
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("quot", 32'(bus.quot), 32'(e.q));
            chk("rem", 32'(bus.rem), 32'(e.r));
            chk("sat", 32'(bus.sat), 32'(e.sat));
            chk("div_zero", 32'(bus.div_zero), 32'(e.dz));
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                #1;
                chk("hold", 32'({bus.out_valid, bus.in_ready, bus.quot, bus.rem, bus.sat, bus.div_zero}),
                    32'({1'b1, 1'b0, e.q, e.r, e.sat, e.dz}));
            end
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("release", 32'({bus.out_valid, bus.in_ready}), 32'b01);
    endtask

    initial begin
        int seen;
        reset         = 1'b1;
        ce            = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outs", 32'({bus.out_valid, bus.quot, bus.rem, bus.sat, bus.div_zero}), 32'd0);
        reset = 1'b0;
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        ce = 1'b0;
        #1;
        chk("ce_low_in_ready", 32'(bus.in_ready), 32'd0);
        ce = 1'b1;

        run_op(100, 7, 1'b0, 1'b0, 0);
        run_op(-100, 7, 1'b0, 1'b0, 0);
        run_op(-1280, 10, 1'b0, 1'b0, 0);
        run_op(1290, 10, 1'b0, 1'b0, 0);
        run_op(500, 0, 1'b0, 1'b0, 0);
        run_op(-100, 0, 1'b0, 1'b0, 0);
        run_op(-4194304, 1, 1'b0, 1'b0, 0);
        run_op(4194303, 32767, 1'b0, 1'b0, 0);
        run_op(-4194176, 32767, 1'b0, 1'b0, 0);
        run_op(32767, 32767, 1'b0, 1'b1, 0);
        run_op(1000, 33, 1'b0, 1'b0, 10);
        run_op(1234, 77, 1'b1, 1'b0, 0);

        // Abort an operation mid-calculation with reset.
        @(negedge clk);
        bus.dividend = 23'd100;
        bus.divisor  = 15'd7;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("mid_rst_outs", 32'({bus.out_valid, bus.quot, bus.rem, bus.sat, bus.div_zero}), 32'd0);
        chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        seen = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen = 1;
        end
        chk("no_stale_valid", 32'(seen), 32'd0);
        run_op(9, 3, 1'b0, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
